// File: rtl/mux_arb_pkg.sv
// Shared types and the circular priority search used by the 4-requester mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, GRANT} state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Walk from the farthest offset back to 'start' so the nearest set bit wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] start);
    pick_t            p;
    logic [SEL_W-1:0] c;
    p.found = 1'b0;
    p.idx   = '0;
    for (int n = N_REQ - 1; n >= 0; n--) begin
      c = start + SEL_W'(n);
      if (req[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4x1.sv
// Combinational 4:1 single-bit multiplexer forming the shared data path.
module mux4x1 (
  input  logic [3:0] i,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = i[sel];

endmodule

// File: rtl/mux4x1_arbiter.sv
// Round-robin owner of a shared 4:1 mux: registered one-hot grant, hold cap of MAX_HOLD
// cycles under contention, and a registered copy of the selected data bit.
module mux4x1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       y
);

  localparam int                CNT_W   = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             y_q, y_d;

  logic [N_REQ-1:0] others;
  logic             own_req;
  logic             mux_y;
  pick_t            pick;

  // With no owner, 'others' is just req, so one search covers idle, release and preemption.
  assign others  = req & ~gnt_q;
  assign own_req = |(req & gnt_q);
  assign pick    = rr_pick(others, ptr_q);

  mux4x1 u_mux (
    .i   (i),
    .sel (sel_q),
    .y   (mux_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    y_d     = (|gnt_q) ? mux_y : 1'b0;

    if ((state_q == IDLE && pick.found) ||
        (state_q == GRANT && pick.found && (!own_req || cnt_q == CNT_MAX))) begin
      state_d = GRANT;
      gnt_d   = N_REQ'(1) << pick.idx;
      sel_d   = pick.idx;
      ptr_d   = pick.idx + SEL_W'(1);
      cnt_d   = '0;
    end else if (state_q == GRANT && !own_req) begin
      state_d = IDLE;
      gnt_d   = '0;
      sel_d   = '0;
      cnt_d   = '0;
    end else if (state_q == GRANT && cnt_q != CNT_MAX) begin
      // Saturates for a lone holder so a late competitor is served on the next edge.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = |gnt_q;
  assign y    = y_q;

endmodule

// File: tb/tb_mux4x1_arbiter.sv
// Scenario bench for mux4x1_arbiter (MAX_HOLD=4) with a cycle-model scoreboard.
module tb_mux4x1_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] i   = '0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       y;

  int tests_run = 0;
  int failures  = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       yy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // Reference model state
  logic       m_idle = 1'b1;
  logic [3:0] m_gnt  = '0;
  logic [1:0] m_sel  = '0;
  int         m_own  = 0;
  int         m_ptr  = 0;
  int         m_cnt  = 0;
  logic       m_y    = 1'b0;

  mux4x1_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .i    (i),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .y    (y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if ({gnt, sel, busy, y} !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got gnt=%b sel=%b busy=%b y=%b want gnt=%b sel=%b busy=%b y=%b",
                 $time, gnt, sel, busy, y, e.g, e.s, e.b, e.yy);
      end
    end
  end

  // Drive one cycle of inputs, advance the model, queue the expected post-edge outputs.
  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] di);
    logic [3:0] pool;
    int         cand;
    logic       take;
    logic       ny;
    @(negedge clk);
    rst = r;
    req = rq;
    i   = di;
    ny  = (!r && m_gnt != 4'b0) ? di[m_sel] : 1'b0;
    if (r) begin
      m_idle = 1'b1; m_gnt = '0; m_sel = '0; m_ptr = 0; m_cnt = 0;
    end else begin
      pool = m_idle ? rq : (rq & ~m_gnt);
      cand = -1;
      for (int k = 0; k < 4; k++)
        if (cand < 0 && pool[(m_ptr + k) % 4]) cand = (m_ptr + k) % 4;
      take = 1'b0;
      if (m_idle) begin
        take = (cand >= 0);
      end else if (!rq[m_own]) begin
        if (cand >= 0) take = 1'b1;
        else begin
          m_idle = 1'b1; m_gnt = '0; m_sel = '0; m_cnt = 0;
        end
      end else if (cand >= 0 && m_cnt == MAXH - 1) begin
        take = 1'b1;
      end else if (m_cnt < MAXH - 1) begin
        m_cnt++;
      end
      if (take) begin
        m_idle = 1'b0; m_own = cand; m_gnt = 4'(1 << cand); m_sel = 2'(cand);
        m_cnt = 0; m_ptr = (cand + 1) % 4;
      end
    end
    m_y = ny;
    exp_q.push_back({m_gnt, m_sel, (m_gnt != 4'b0), m_y});
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      cyc(1'b1, 4'b1111, 4'b1111);
      tests_run++;
      if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0 || y !== 1'b0) begin
        failures++;
        $display("FAIL reset cyc%0d got gnt=%b sel=%b busy=%b y=%b want 0000/00/0/0", n, gnt, sel, busy, y);
      end
    end
  endtask

  task automatic test_single();
    cyc(1'b0, 4'b0100, 4'b0100);
    tests_run++;
    if (gnt !== 4'b0100 || sel !== 2'b10 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got gnt=%b sel=%b busy=%b want 0100/10/1", gnt, sel, busy);
    end
    cyc(1'b0, 4'b0100, 4'b0100);
    tests_run++;
    if (y !== 1'b1) begin
      failures++;
      $display("FAIL single_y got y=%b want 1", y);
    end
    cyc(1'b0, 4'b0000, 4'b0100);
    tests_run++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_release got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    cyc(1'b1, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b1111, 4'b1010);
    tests_run++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL rr_first got gnt=%b want 0001", gnt);
    end
    for (int g = 0; g < 4; g++) begin
      cyc(1'b0, 4'b1111, 4'b1010);
      want = 4'(1 << g);
      tests_run++;
      if (gnt !== want) begin
        failures++;
        $display("FAIL rr_hold%0d got gnt=%b want %b", g, gnt, want);
      end
      cyc(1'b0, 4'b1111 & ~want, 4'b1010);
      want = 4'(1 << ((g + 1) % 4));
      tests_run++;
      if (gnt !== want) begin
        failures++;
        $display("FAIL rr_handover%0d got gnt=%b want %b", g, gnt, want);
      end
    end
    cyc(1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic test_preempt();
    logic [3:0] wg;
    logic [1:0] ws;
    cyc(1'b1, 4'b0000, 4'b0000);
    for (int n = 0; n < 12; n++) begin
      cyc(1'b0, 4'b0011, 4'b0010);
      wg = (n >= 4 && n < 8) ? 4'b0010 : 4'b0001;
      ws = (n >= 4 && n < 8) ? 2'b01 : 2'b00;
      tests_run++;
      if (gnt !== wg || sel !== ws) begin
        failures++;
        $display("FAIL preempt cyc%0d got gnt=%b sel=%b want %b/%b", n, gnt, sel, wg, ws);
      end
    end
    cyc(1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic test_lone_holder();
    for (int n = 0; n < 20; n++) begin
      cyc(1'b0, 4'b1000, 4'b1000);
      tests_run++;
      if (gnt !== 4'b1000) begin
        failures++;
        $display("FAIL lone cyc%0d got gnt=%b want 1000", n, gnt);
      end
    end
    cyc(1'b0, 4'b1001, 4'b0001);
    tests_run++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL lone_saturated_preempt got gnt=%b want 0001", gnt);
    end
    cyc(1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 4'b0010, 4'b1111);
    cyc(1'b0, 4'b0010, 4'b1111);
    tests_run++;
    if (gnt !== 4'b0010 || y !== 1'b1) begin
      failures++;
      $display("FAIL midrst_setup got gnt=%b y=%b want 0010/1", gnt, y);
    end
    cyc(1'b1, 4'b0011, 4'b1111);
    tests_run++;
    if (gnt !== 4'b0000 || y !== 1'b0) begin
      failures++;
      $display("FAIL midrst_drop got gnt=%b y=%b want 0000/0", gnt, y);
    end
    cyc(1'b0, 4'b0011, 4'b0000);
    tests_run++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_ptr got gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] rq;
    rq = 4'b0;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) rq = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 39) == 0), rq, 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_lone_holder();
    test_reset_mid();
    test_random();
    @(posedge clk);
    #3;
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
